// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decodes instruction fields into ALU operand pairs at
// capture time and holds them in a DEPTH-entry FIFO for the execute stage.
// Unsupported opcodes pass through with ALU_EN=0 and bump a saturating counter.
// Optional feature macro: ALU_OPERAND_FWD_EN (writeback bypass onto RS1/RS2 values).
module alu_operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic [4:0]       RS1,
  input  logic [4:0]       RS2,
  input  logic [XLEN-1:0]  RS1_DATA,
  input  logic [XLEN-1:0]  RS2_DATA,
  input  logic [XLEN-1:0]  PC,
  input  logic [11:0]      IMM12,
  input  logic [19:0]      U_IMM20,
  input  logic             WB_VALID,
  input  logic [4:0]       WB_RD,
  input  logic [XLEN-1:0]  WB_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  DATA0,
  output logic [XLEN-1:0]  DATA1,
  output logic             ALU_EN,
  output logic [2:0]       OUT_FUNCT3,
  output logic [CNT_W-1:0] ILLEGAL_CNT
);

  localparam int unsigned SH    = $clog2(XLEN);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned OCC_W = PW + 1;
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  logic [XLEN-1:0]  rs1v, rs2v;
  logic [XLEN-1:0]  imm_sext, uimm, imm_shamt, rs2_shamt;
  logic             is_shift;
  logic [XLEN-1:0]  cap_d0, cap_d1;
  logic             cap_en, cap_illegal;

  logic [XLEN-1:0]  mem_d0 [DEPTH];
  logic [XLEN-1:0]  mem_d1 [DEPTH];
  logic             mem_en [DEPTH];
  logic [2:0]       mem_f3 [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OCC_W-1:0] count;
  logic             enq, deq;

  // Source operand selection, optionally bypassing the writeback result
  always_comb begin
    rs1v = RS1_DATA;
    rs2v = RS2_DATA;
`ifdef ALU_OPERAND_FWD_EN
    if (WB_VALID && (WB_RD != 5'd0) && (WB_RD == RS1)) rs1v = WB_DATA;
    if (WB_VALID && (WB_RD != 5'd0) && (WB_RD == RS2)) rs2v = WB_DATA;
`endif
  end

`ifndef ALU_OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{WB_VALID, WB_RD, WB_DATA, RS1, RS2};
`endif

  assign imm_sext  = XLEN'(signed'(IMM12));
  assign uimm      = XLEN'(signed'({U_IMM20, 12'b0}));
  assign imm_shamt = XLEN'(IMM12[SH-1:0]);
  assign rs2_shamt = XLEN'(rs2v[SH-1:0]);
  assign is_shift  = (FUNCT3 == 3'b001) || (FUNCT3 == 3'b101);

  // Operand decode for the entry being captured this cycle
  always_comb begin
    cap_d0      = '0;
    cap_d1      = '0;
    cap_en      = 1'b1;
    cap_illegal = 1'b0;
    case (OPCODE)
      OPC_OP_IMM: begin
        cap_d0 = rs1v;
        cap_d1 = is_shift ? imm_shamt : imm_sext;
      end
      OPC_OP: begin
        cap_d0 = rs1v;
        cap_d1 = is_shift ? rs2_shamt : rs2v;
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        cap_d0 = rs1v;
        cap_d1 = imm_sext;
      end
      OPC_LUI: begin
        cap_d0 = '0;
        cap_d1 = uimm;
      end
      OPC_AUIPC: begin
        cap_d0 = PC;
        cap_d1 = uimm;
      end
      default: begin
        cap_en      = 1'b0;
        cap_illegal = 1'b1;
      end
    endcase
  end

  // IN_READY depends only on stored occupancy, so a dequeue frees space next cycle
  assign IN_READY  = (count != FULL_CNT);
  assign OUT_VALID = (count != '0);
  assign enq       = IN_VALID && IN_READY;
  assign deq       = OUT_VALID && OUT_READY;

  // Head-of-queue view, forced to zero while empty (including during reset)
  assign DATA0      = OUT_VALID ? mem_d0[rd_ptr] : '0;
  assign DATA1      = OUT_VALID ? mem_d1[rd_ptr] : '0;
  assign ALU_EN     = OUT_VALID ? mem_en[rd_ptr] : 1'b0;
  assign OUT_FUNCT3 = OUT_VALID ? mem_f3[rd_ptr] : 3'b000;

  // Queue storage write; contents are don't-care until occupancy covers them
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_d0[wr_ptr] <= cap_d0;
      mem_d1[wr_ptr] <= cap_d1;
      mem_en[wr_ptr] <= cap_en;
      mem_f3[wr_ptr] <= FUNCT3;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Saturating count of accepted unsupported opcodes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ILLEGAL_CNT <= '0;
    end else if (enq && cap_illegal && (ILLEGAL_CNT != '1)) begin
      ILLEGAL_CNT <= ILLEGAL_CNT + 1'b1;
    end
  end

endmodule
